index_stream_decoder: RTL

- Decoder-side counterpart of the team's priority encoder. It accepts a stream of binary indices over a valid/ready handshake.
- Each index is decoded to one-hot and OR-accumulated into a bit vector; the frame ends on the beat flagged last.
- The reconstructed vector is presented on a registered valid/ready output port with beat-count and error flags.
- Sits downstream of index producers (encoders, arbiters) to rebuild request/grant masks.

---
 rtl/index_stream_decoder_if.sv | 26 ++
 rtl/index_stream_decoder.sv | 72 +++++++
 2 files changed

// File: rtl/index_stream_decoder_if.sv
// index_stream_decoder_if: index-beat input and frame-result output bundle for index_stream_decoder
// slave: decoder side (drives in_ready and all out_* results); master: producer/consumer side.
interface index_stream_decoder_if #(
  parameter int OUTPUT_BIT = 8,
  parameter int INPUT_BIT = $clog2(OUTPUT_BIT),
  parameter int CNT_BIT = 8
);
  logic in_valid;
  logic in_ready;
  logic [INPUT_BIT-1:0] in_idx;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [OUTPUT_BIT-1:0] out_vec;
  logic [CNT_BIT-1:0] out_cnt;
  logic dup_err;
  logic range_err;
  modport slave (
    input in_valid, in_idx, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_cnt, dup_err, range_err
  );
  modport master (
    output in_valid, in_idx, in_last, out_ready,
    input in_ready, out_valid, out_vec, out_cnt, dup_err, range_err
  );
endinterface

// File: rtl/index_stream_decoder.sv
// index_stream_decoder: OR-accumulates one-hot decoded index beats into a vector per frame
// Ports: clk; rst_n (async active-low); bus (slave modport) carrying in_valid/in_ready/in_idx/in_last
// beats and the registered out_valid/out_ready result with out_vec, out_cnt (saturating), dup_err, range_err.
// Optional macro DEC_BACKTOBACK_EN: accept the next frame's first beat in the output handshake cycle.
module index_stream_decoder #(
  parameter int OUTPUT_BIT = 8,
  parameter int INPUT_BIT = $clog2(OUTPUT_BIT),
  parameter int CNT_BIT = 8
) (
  input logic clk,
  input logic rst_n,
  index_stream_decoder_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [INPUT_BIT:0] LIMIT = (INPUT_BIT+1)'(OUTPUT_BIT);
  state_t state;
  logic [OUTPUT_BIT-1:0] acc, onehot, acc_n;
  logic [CNT_BIT-1:0] cnt, cnt_n;
  logic dup, rng, bad_idx, dup_n, rng_n, take, drain;
  // acc/cnt/flags are zeroed when a frame is loaded, so in HOLD they already
  // describe an empty frame and a back-to-back beat starts from scratch.
  always_comb begin
    bad_idx = {1'b0, bus.in_idx} >= LIMIT;
    onehot = bad_idx ? '0 : OUTPUT_BIT'(1) << bus.in_idx;
    acc_n = acc | onehot;
    cnt_n = &cnt ? cnt : cnt + 1'b1;
    dup_n = dup | (|(acc & onehot));
    rng_n = rng | bad_idx;
  end
  assign drain = state == HOLD && bus.out_ready;
`ifdef DEC_BACKTOBACK_EN
  assign bus.in_ready = state == ACCUM || bus.out_ready;
`else
  assign bus.in_ready = state == ACCUM;
`endif
  assign take = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      dup <= 1'b0;
      rng <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_vec <= '0;
      bus.out_cnt <= '0;
      bus.dup_err <= 1'b0;
      bus.range_err <= 1'b0;
    end else begin
      if (drain) begin
        state <= ACCUM;
        bus.out_valid <= 1'b0;
      end
      if (take && bus.in_last) begin
        state <= HOLD;
        bus.out_valid <= 1'b1;
        bus.out_vec <= acc_n;
        bus.out_cnt <= cnt_n;
        bus.dup_err <= dup_n;
        bus.range_err <= rng_n;
        acc <= '0;
        cnt <= '0;
        dup <= 1'b0;
        rng <= 1'b0;
      end else if (take) begin
        acc <= acc_n;
        cnt <= cnt_n;
        dup <= dup_n;
        rng <= rng_n;
      end
    end
endmodule
